// File: rtl/sdram_port_arb_if.sv
// Bundle between sdram_port_arb, the four per-port FIFO requesters and sdram_ctrl.
//   master : the arbiter view (drives controller requests, per-port acks, status)
//   slave  : the environment view (requesters plus controller)
// Port slots are packed LSB-first: port p occupies [W*p +: W] of each vector.
interface sdram_port_arb_if;
  localparam int unsigned N_PORTS = 4;
  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned LEN_W   = 10;
  localparam int unsigned DATA_W  = 16;

  logic                          init_end;
  logic [N_PORTS-1:0]            p_wr_req;
  logic [N_PORTS*ADDR_W-1:0]     p_wr_addr;
  logic [N_PORTS*LEN_W-1:0]      p_wr_len;
  logic [N_PORTS*DATA_W-1:0]     p_wr_data;
  logic [N_PORTS-1:0]            p_wr_ack;
  logic [N_PORTS-1:0]            p_rd_req;
  logic [N_PORTS*ADDR_W-1:0]     p_rd_addr;
  logic [N_PORTS*LEN_W-1:0]      p_rd_len;
  logic [N_PORTS-1:0]            p_rd_ack;
  logic [DATA_W-1:0]             p_rd_data;
  logic                          sdram_wr_req;
  logic [ADDR_W-1:0]             sdram_wr_addr;
  logic [LEN_W-1:0]              wr_burst_len;
  logic [DATA_W-1:0]             sdram_data_in;
  logic                          sdram_wr_ack;
  logic                          sdram_rd_req;
  logic [ADDR_W-1:0]             sdram_rd_addr;
  logic [LEN_W-1:0]              rd_burst_len;
  logic [DATA_W-1:0]             sdram_data_out;
  logic                          sdram_rd_ack;
  logic [2:0]                    grant_id;
  logic                          busy;
  logic                          to_err;

  modport master (
    input  init_end,
    input  p_wr_req, p_wr_addr, p_wr_len, p_wr_data,
    output p_wr_ack,
    input  p_rd_req, p_rd_addr, p_rd_len,
    output p_rd_ack, p_rd_data,
    output sdram_wr_req, sdram_wr_addr, wr_burst_len, sdram_data_in,
    input  sdram_wr_ack,
    output sdram_rd_req, sdram_rd_addr, rd_burst_len,
    input  sdram_data_out, sdram_rd_ack,
    output grant_id, busy, to_err
  );

  modport slave (
    output init_end,
    output p_wr_req, p_wr_addr, p_wr_len, p_wr_data,
    input  p_wr_ack,
    output p_rd_req, p_rd_addr, p_rd_len,
    input  p_rd_ack, p_rd_data,
    input  sdram_wr_req, sdram_wr_addr, wr_burst_len, sdram_data_in,
    output sdram_wr_ack,
    input  sdram_rd_req, sdram_rd_addr, rd_burst_len,
    output sdram_data_out, sdram_rd_ack,
    input  grant_id, busy, to_err
  );
endinterface

// File: rtl/sdram_port_arb.sv
// Four-port round-robin burst scheduler in front of sdram_ctrl.
// Eight request slots (2p = write port p, 2p+1 = read port p) share the single
// controller write and read ports; one burst is granted at a time.
// Ports:
//   sys_clk  : system clock
//   sys_rst  : synchronous active-high reset
//   bus      : sdram_port_arb_if.master (requesters, controller, status)
// Registered: controller requests/addr/len, grant_id, busy, to_err.
// Combinational: per-port acks, sdram_data_in mux, p_rd_data pass-through.
module sdram_port_arb #(
  parameter int unsigned TO_CYCLES = 2048
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  sdram_port_arb_if.master   bus
);

  localparam int unsigned N_PORTS = 4;
  localparam int unsigned N_SLOTS = 2 * N_PORTS;
  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned LEN_W   = 10;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CNT_W   = 12;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  logic [2:0]         ptr;
  logic [CNT_W-1:0]   cnt;

  logic [N_SLOTS-1:0] eligible;
  logic               found;
  logic [2:0]         winner;
  logic [2:0]         cand;
  logic               ack_match;
  logic               in_burst;

  logic [ADDR_W-1:0]  wr_addr_a [N_PORTS];
  logic [ADDR_W-1:0]  rd_addr_a [N_PORTS];
  logic [LEN_W-1:0]   wr_len_a  [N_PORTS];
  logic [LEN_W-1:0]   rd_len_a  [N_PORTS];
  logic [DATA_W-1:0]  wr_data_a [N_PORTS];

  // Unpack per-port fields and derive slot eligibility (req high, len nonzero).
  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    assign wr_addr_a[p]     = bus.p_wr_addr[ADDR_W*p +: ADDR_W];
    assign rd_addr_a[p]     = bus.p_rd_addr[ADDR_W*p +: ADDR_W];
    assign wr_len_a[p]      = bus.p_wr_len[LEN_W*p +: LEN_W];
    assign rd_len_a[p]      = bus.p_rd_len[LEN_W*p +: LEN_W];
    assign wr_data_a[p]     = bus.p_wr_data[DATA_W*p +: DATA_W];
    assign eligible[2*p]    = bus.p_wr_req[p] && (wr_len_a[p] != '0);
    assign eligible[2*p+1]  = bus.p_rd_req[p] && (rd_len_a[p] != '0);
  end

  // Round-robin search starting just after the last served slot; the
  // eighth candidate wraps back onto ptr itself so a lone requester still wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 1; i <= int'(N_SLOTS); i++) begin
      cand = ptr + 3'(i);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign in_burst  = (state == REQ) || (state == XFER);
  assign ack_match = bus.grant_id[0] ? bus.sdram_rd_ack : bus.sdram_wr_ack;

  // Forward controller acks only to the granted port while a burst is live.
  always_comb begin
    bus.p_wr_ack = '0;
    bus.p_rd_ack = '0;
    if (in_burst) begin
      if (bus.grant_id[0]) bus.p_rd_ack[bus.grant_id[2:1]] = bus.sdram_rd_ack;
      else                 bus.p_wr_ack[bus.grant_id[2:1]] = bus.sdram_wr_ack;
    end
  end

  // Write data follows the granted port; read data is broadcast.
  assign bus.sdram_data_in = wr_data_a[bus.grant_id[2:1]];
  assign bus.p_rd_data     = bus.sdram_data_out;

  // Scheduler state and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state             <= IDLE;
      ptr               <= 3'd7;
      cnt               <= '0;
      bus.grant_id      <= '0;
      bus.busy          <= 1'b0;
      bus.to_err        <= 1'b0;
      bus.sdram_wr_req  <= 1'b0;
      bus.sdram_wr_addr <= '0;
      bus.wr_burst_len  <= '0;
      bus.sdram_rd_req  <= 1'b0;
      bus.sdram_rd_addr <= '0;
      bus.rd_burst_len  <= '0;
    end else begin
      bus.to_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.init_end && found) begin
            state        <= REQ;
            bus.busy     <= 1'b1;
            bus.grant_id <= winner;
            cnt          <= '0;
            if (winner[0]) begin
              bus.sdram_rd_req  <= 1'b1;
              bus.sdram_rd_addr <= rd_addr_a[winner[2:1]];
              bus.rd_burst_len  <= rd_len_a[winner[2:1]];
            end else begin
              bus.sdram_wr_req  <= 1'b1;
              bus.sdram_wr_addr <= wr_addr_a[winner[2:1]];
              bus.wr_burst_len  <= wr_len_a[winner[2:1]];
            end
          end
        end
        REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (ack_match) begin
            state            <= XFER;
            bus.sdram_wr_req <= 1'b0;
            bus.sdram_rd_req <= 1'b0;
          end else if (cnt == TO_LAST) begin
            // Controller never answered: abandon the burst.
            state            <= DONE;
            bus.to_err       <= 1'b1;
            bus.sdram_wr_req <= 1'b0;
            bus.sdram_rd_req <= 1'b0;
          end
        end
        XFER: begin
          if (!ack_match) state <= DONE;
        end
        DONE: begin
          // Recording the served slot pushes it to the back of the rotation.
          state    <= IDLE;
          ptr      <= bus.grant_id;
          cnt      <= '0;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
